alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DIV_CYCLES, default 4, total latency in cycles of a divide; legal range 2..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts port N this cycle; transfer = valid & ready.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands, unsigned.
REQ-007 req0_sel / req1_sel  input  4  opcode: 1001 add, 1000 sub, 0100 mul, 0001 div, 0101 and, 0110 or, 0010 nor, 0111 slt.
REQ-008 resp0_valid / resp1_valid  output  1  one-cycle pulse, result for port N; no backpressure.
REQ-009 resp0_data / resp1_data  output  32  registered result, held until next response to that port.

Function
REQ-010 States: IDLE (ready may assert) and DIV_BUSY (both ready low).
REQ-011 In IDLE, req_ready is combinational: asserted for exactly one port, the grant winner among valid ports; never for an invalid port.
REQ-012 Round-robin: both valid -> grant port not granted last; one valid -> grant it; last-grant register updates on every transfer only.
REQ-013 Accepted operands and opcode are captured into internal registers at the transfer edge; later input changes have no effect.
REQ-014 Non-divide ops: transfer in cycle T -> resp_valid of granted port high in T+1; state stays IDLE; one transfer per cycle sustained.
REQ-015 Divide: transfer in T -> DIV_BUSY for T+1..T+DIV_CYCLES-1 via down-counter; resp_valid in T+DIV_CYCLES; IDLE (ready allowed) in T+DIV_CYCLES.
REQ-016 Arithmetic mod 2^32: add, sub wrap; mul keeps low 32 bits; div unsigned quotient; and/or bitwise; nor = bitwise ~(a|b); slt = 1 if a<b unsigned else 0.
REQ-017 Divide by zero -> result 0xFFFFFFFF, normal latency.
REQ-018 Undefined opcode -> result 0x00000000, latency 1.
REQ-019 Only the granted port's resp_valid pulses; the other port's resp_data is unchanged.
REQ-020 A requester's valid held low while ready low is legal; arbiter never drops or duplicates a transfer.

Reset
REQ-021 rst_n low: state IDLE, counter 0, last-grant = port 1 (port 0 wins first tie), resp_valid 0, resp_data 0, captured registers 0.
REQ-022 Reset asserted mid-divide aborts it: no resp_valid after release; first cycle after release is IDLE.

Configuration
REQ-023 Macro ALU_ARB_ERR_EN defined: adds outputs resp0_err / resp1_err (1 bit), asserted with resp_valid for divide-by-zero or undefined opcode, else 0, reset 0.
REQ-024 ALU_ARB_ERR_EN undefined: err ports absent; all other behaviour identical.

Structure
REQ-025 Shared package alu_pkg holds opcode constants, the state enum and the DIV_CYCLES default.
REQ-026 One sub-module alu_core: combinational, single instance, computes REQ-016..018 from captured registers; arbiter holds all sequential logic.

Verification
REQ-027 Port0 only, add 5+7 at T -> resp0_valid at T+1, resp0_data 12; resp1_valid never asserts.
REQ-028 Both valid every cycle, port0 sub 3-5, port1 or 0xF0|0x0F -> grants alternate 0,1,0,1; resp0 0xFFFFFFFE, resp1 0xFF.
REQ-029 Port1 div 100/7 at T, DIV_CYCLES=4, port0 valid throughout -> both ready low T+1..T+3; resp1 14 at T+4; port0 granted at T+4.
REQ-030 Div 9/0 and sel 0011 -> results 0xFFFFFFFF and 0; with ALU_ARB_ERR_EN err pulses on both.
REQ-031 mul 0x10000*0x10000 -> 0; slt 1<0xFFFFFFFF -> 1; nor 0|0 -> 0xFFFFFFFF.
REQ-032 rst_n low at T+2 of a divide -> no resp for it; after release port0 wins first tie.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM states and
// the default divide latency.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b1001;
   localparam logic [3:0] OP_SUB = 4'b1000;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b0010;
   localparam logic [3:0] OP_SLT = 4'b0111;

   localparam int DIV_CYCLES_DEF = 4;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_DIV_BUSY = 1'b1
   } arb_state_t;

   function automatic logic op_is_div(input logic [3:0] sel);
      return (sel == OP_DIV);
   endfunction

   function automatic logic op_is_defined(input logic [3:0] sel);
      logic ok;
      case (sel)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV,
         OP_AND, OP_OR, OP_NOR, OP_SLT: ok = 1'b1;
         default:                       ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Error condition: divide by zero or an opcode outside the defined set.
   function automatic logic op_err(input logic [3:0] sel, input logic [31:0] b);
      return (!op_is_defined(sel)) || (op_is_div(sel) && (b == 32'h0000_0000));
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU shared by both arbiter ports; all
// arithmetic wraps modulo 2^32.
module alu_core
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [3:0]  sel,
   input  logic [31:0] b,
   output logic [31:0] result
);

   // Opcode decode and result selection.
   always_comb begin
      result = 32'h0000_0000;
      case (sel)
         OP_ADD: result = a + b;
         OP_SUB: result = a - b;
         OP_MUL: result = a * b;
         OP_DIV: begin
            if (b == 32'h0000_0000) begin
               result = 32'hFFFF_FFFF;
            end else begin
               result = a / b;
            end
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_NOR: result = ~(a | b);
         OP_SLT: result = (a < b) ? 32'h0000_0001 : 32'h0000_0000;
         default: result = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared ALU with a multi-cycle divide.
// Optional macro ALU_ARB_ERR_EN adds resp0_err / resp1_err flags.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_sel,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_sel,
   output logic        resp0_valid,
   output logic [31:0] resp0_data,
   output logic        resp1_valid,
   output logic [31:0] resp1_data
`ifdef ALU_ARB_ERR_EN
   ,
   output logic        resp0_err,
   output logic        resp1_err
`endif
);

   localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 2);

   arb_state_t  state_r, state_nxt_s;
   logic [3:0]  cnt_r, cnt_nxt_s;
   logic        last_r;
   logic [31:0] cap_a_r, cap_b_r;
   logic [3:0]  cap_sel_r;
   logic        cap_port_r;

   logic        gnt1_s;
   logic        xfer_s;
   logic        done_s;
   logic        done_port_s;
   logic [31:0] op_a_s, op_b_s;
   logic [3:0]  op_sel_s;
   logic [31:0] core_res_s;

   // Round-robin winner and combinational ready, only while idle.
   always_comb begin
      gnt1_s = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt1_s = ~last_r;
      end else if (req1_valid) begin
         gnt1_s = 1'b1;
      end else begin
         gnt1_s = 1'b0;
      end
      req0_ready = (state_r == ST_IDLE) && req0_valid && !gnt1_s;
      req1_ready = (state_r == ST_IDLE) && req1_valid &&  gnt1_s;
      xfer_s     = req0_ready || req1_ready;
   end

   // Single-cycle ops are evaluated on the winner's live operands (the same
   // values being captured); a finishing divide uses the captured copy.
   always_comb begin
      op_a_s   = cap_a_r;
      op_b_s   = cap_b_r;
      op_sel_s = cap_sel_r;
      if (state_r == ST_IDLE) begin
         if (gnt1_s) begin
            op_a_s   = req1_a;
            op_b_s   = req1_b;
            op_sel_s = req1_sel;
         end else begin
            op_a_s   = req0_a;
            op_b_s   = req0_b;
            op_sel_s = req0_sel;
         end
      end else begin
         op_a_s   = cap_a_r;
         op_b_s   = cap_b_r;
         op_sel_s = cap_sel_r;
      end
   end

   alu_core u_core (
      .a      (op_a_s),
      .sel    (op_sel_s),
      .b      (op_b_s),
      .result (core_res_s)
   );

   // Next-state logic: a divide parks in DIV_BUSY until the counter empties.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      done_s      = 1'b0;
      done_port_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s) begin
               if (op_is_div(op_sel_s)) begin
                  state_nxt_s = ST_DIV_BUSY;
                  cnt_nxt_s   = DIV_LOAD;
               end else begin
                  done_s      = 1'b1;
                  done_port_s = gnt1_s;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DIV_BUSY: begin
            if (cnt_r == 4'd0) begin
               state_nxt_s = ST_IDLE;
               done_s      = 1'b1;
               done_port_s = cap_port_r;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // State and divide counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Operand capture and last-grant tracking on each transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_a_r    <= 32'h0000_0000;
         cap_b_r    <= 32'h0000_0000;
         cap_sel_r  <= 4'h0;
         cap_port_r <= 1'b0;
         last_r     <= 1'b1;
      end else if (xfer_s) begin
         cap_a_r    <= op_a_s;
         cap_b_r    <= op_b_s;
         cap_sel_r  <= op_sel_s;
         cap_port_r <= gnt1_s;
         last_r     <= gnt1_s;
      end
   end

   // Registered responses; data holds until that port's next response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         resp0_data  <= 32'h0000_0000;
         resp1_data  <= 32'h0000_0000;
      end else begin
         resp0_valid <= done_s && !done_port_s;
         resp1_valid <= done_s &&  done_port_s;
         if (done_s && !done_port_s) begin
            resp0_data <= core_res_s;
         end
         if (done_s && done_port_s) begin
            resp1_data <= core_res_s;
         end
      end
   end

`ifdef ALU_ARB_ERR_EN
   logic core_err_s;
   assign core_err_s = op_err(op_sel_s, op_b_s);

   // Error flags pulse alongside the matching response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp0_err <= 1'b0;
         resp1_err <= 1'b0;
      end else begin
         resp0_err <= done_s && !done_port_s && core_err_s;
         resp1_err <= done_s &&  done_port_s && core_err_s;
      end
   end
`else
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a cycle-level reference model checked every
// cycle, plus hand-computed per-port result lists.
module tb_alu_arbiter;

   localparam int DIVC = 4;
   localparam int NL0  = 9;
   localparam int NL1  = 7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_sel, req1_sel;
   logic        resp0_valid, resp1_valid;
   logic [31:0] resp0_data, resp1_data;
`ifdef ALU_ARB_ERR_EN
   logic        resp0_err, resp1_err;
`endif

   alu_arbiter #(.DIV_CYCLES(DIVC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .resp0_valid(resp0_valid), .resp0_data(resp0_data),
      .resp1_valid(resp1_valid), .resp1_data(resp1_data)
`ifdef ALU_ARB_ERR_EN
      , .resp0_err(resp0_err), .resp1_err(resp1_err)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] lit0 [NL0] = '{32'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_000F,
                               32'h0000_000F, 32'hFFFF_FFFF, 32'h0000_0000,
                               32'hFFFF_FFFF, 32'd2};
   logic [31:0] lit1 [NL1] = '{32'h0000_00FF, 32'h0000_00FF, 32'd14, 32'h0000_0000,
                               32'd1, 32'd0, 32'd4};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference semantics: {err, result}
   function automatic logic [32:0] model_op(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (s)
         4'b1001: return {1'b0, 32'(a + b)};
         4'b1000: return {1'b0, 32'(a - b)};
         4'b0100: return {1'b0, p[31:0]};
         4'b0001: return (b == 32'd0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, 32'(a / b)};
         4'b0101: return {1'b0, a & b};
         4'b0110: return {1'b0, a | b};
         4'b0010: return {1'b0, ~(a | b)};
         4'b0111: return {1'b0, (a < b) ? 32'd1 : 32'd0};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   int          cyc = 0;
   int          pend0 = -1, pend1 = -1, busy_until = 0;
   logic [31:0] pd0, pd1, md0 = 32'd0, md1 = 32'd0;
   logic        pe0, pe1, mlast = 1'b1;
   int          li0 = 0, li1 = 0;
   logic        ev0, ev1, midle, g1, er0, er1, final_req = 1'b0, final_done = 1'b0;
   logic [32:0] r;

   // Compare process: model and DUT evaluated away from the rising edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
         chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
         chk("rst_resp0_data", resp0_data, 32'd0);
         chk("rst_resp1_data", resp1_data, 32'd0);
         mlast = 1'b1; busy_until = 0; pend0 = -1; pend1 = -1;
         md0 = 32'd0; md1 = 32'd0;
      end else begin
         ev0 = (pend0 == cyc);
         ev1 = (pend1 == cyc);
         if (ev0) md0 = pd0;
         if (ev1) md1 = pd1;
         chk("resp0_valid", 32'(resp0_valid), 32'(ev0));
         chk("resp1_valid", 32'(resp1_valid), 32'(ev1));
         chk("resp0_data", resp0_data, md0);
         chk("resp1_data", resp1_data, md1);
`ifdef ALU_ARB_ERR_EN
         chk("resp0_err", 32'(resp0_err), 32'(ev0 && pe0));
         chk("resp1_err", 32'(resp1_err), 32'(ev1 && pe1));
`endif
         if (resp0_valid) begin
            if (li0 < NL0) chk("lit_resp0", resp0_data, lit0[li0]);
            li0++;
         end
         if (resp1_valid) begin
            if (li1 < NL1) chk("lit_resp1", resp1_data, lit1[li1]);
            li1++;
         end
         midle = (cyc >= busy_until);
         g1    = (req0_valid && req1_valid) ? !mlast : req1_valid;
         er0   = midle && req0_valid && !g1;
         er1   = midle && req1_valid && g1;
         chk("req0_ready", 32'(req0_ready), 32'(er0));
         chk("req1_ready", 32'(req1_ready), 32'(er1));
         if (er0) begin
            r = model_op(req0_a, req0_b, req0_sel);
            pd0 = r[31:0]; pe0 = r[32];
            pend0 = cyc + ((req0_sel == 4'b0001) ? DIVC : 1);
            if (req0_sel == 4'b0001) busy_until = cyc + DIVC;
            mlast = 1'b0;
         end else if (er1) begin
            r = model_op(req1_a, req1_b, req1_sel);
            pd1 = r[31:0]; pe1 = r[32];
            pend1 = cyc + ((req1_sel == 4'b0001) ? DIVC : 1);
            if (req1_sel == 4'b0001) busy_until = cyc + DIVC;
            mlast = 1'b1;
         end
      end
      if (final_req && !final_done) begin
         chk("resp0_count", 32'(li0), 32'(NL0));
         chk("resp1_count", 32'(li1), 32'(NL1));
         final_done = 1'b1;
      end
   end

   task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] s0, input logic v1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [3:0] s1);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0);
   endtask

   initial begin
      req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_sel = 4'd0;
      req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_sel = 4'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // port0 add 5+7 -> 12
      step(1'b1, 32'd5, 32'd7, 4'b1001, 1'b0, 32'd0, 32'd0, 4'd0);
      idle(3);

      // fresh reset, then both valid: grants alternate 0,1,0,1
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      repeat (4) step(1'b1, 32'd3, 32'd5, 4'b1000, 1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0110);
      idle(2);

      // port0 alone once, then port1 divide 100/7 while port0 keeps requesting
      step(1'b1, 32'hFF, 32'h0F, 4'b0101, 1'b0, 32'd0, 32'd0, 4'd0);
      step(1'b1, 32'hFF, 32'h0F, 4'b0101, 1'b1, 32'd100, 32'd7, 4'b0001);
      repeat (4) step(1'b1, 32'hFF, 32'h0F, 4'b0101, 1'b0, 32'd0, 32'd0, 4'd0);
      idle(2);

      // divide by zero, then undefined opcode
      step(1'b1, 32'd9, 32'd0, 4'b0001, 1'b0, 32'd0, 32'd0, 4'd0);
      idle(5);
      step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'd3, 32'd4, 4'b0011);
      idle(2);

      // mul wrap, slt true, nor, slt false
      step(1'b1, 32'h0001_0000, 32'h0001_0000, 4'b0100, 1'b0, 32'd0, 32'd0, 4'd0);
      idle(1);
      step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'd1, 32'hFFFF_FFFF, 4'b0111);
      step(1'b1, 32'd0, 32'd0, 4'b0010, 1'b0, 32'd0, 32'd0, 4'd0);
      step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'd5, 32'd3, 4'b0111);
      idle(2);

      // reset in the third cycle of a divide aborts it; port0 wins the first tie
      step(1'b1, 32'd50, 32'd5, 4'b0001, 1'b0, 32'd0, 32'd0, 4'd0);
      idle(1);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      repeat (2) step(1'b1, 32'd1, 32'd1, 4'b1001, 1'b1, 32'd2, 32'd2, 4'b1001);
      idle(6);

      final_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
